mem_lsu: RTL and testbench

//  MEM-stage load/store unit. It consumes the ex_mem outputs and runs one

---
 rtl/mem_lsu_pkg.sv | 34 +++
 rtl/mem_lsu_if.sv | 16 +
 rtl/mem_lsu_lane.sv | 59 +++++
 rtl/mem_lsu.sv | 127 ++++++++++++
 tb/tb_mem_lsu.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared op codes, FSM state encoding and the lane-decode result type for the MEM-stage LSU.
// Op codes match the ex_mem aluop field; anything not listed here is a non-memory op.
package mem_lsu_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic        STOP          = 1'b1;
  localparam logic        NO_STOP       = 1'b0;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_BUSY = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic        is_mem;
    logic        is_load;
    logic        misalign;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } lane_t;

endpackage

// File: rtl/mem_lsu_if.sv
// Request/acknowledge data bus between the LSU (master) and data memory (slave).
// ack is a single-cycle strobe; rdata is only meaningful while ack is high.
interface mem_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        sel;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;

  modport master (output req, we, addr, sel, wdata, input rdata, ack);
  modport slave  (input req, we, addr, sel, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_lane.sv
// Combinational big-endian lane steering: byte enables, replicated store data,
// extended load result and alignment check. Zero latency, no flow control.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output lane_t       lane_o
);

  logic [7:0]  byte_dat;
  logic [15:0] half_dat;

  // sel[3] / rdata[31:24] is the byte at offset 0
  always_comb begin
    case (off_i)
      2'd0:    byte_dat = rdata_i[31:24];
      2'd1:    byte_dat = rdata_i[23:16];
      2'd2:    byte_dat = rdata_i[15:8];
      default: byte_dat = rdata_i[7:0];
    endcase
    half_dat = off_i[1] ? rdata_i[15:0] : rdata_i[31:16];
  end

  always_comb begin
    lane_o = '0;
    case (aluop_i)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        lane_o.is_mem  = 1'b1;
        lane_o.is_load = (aluop_i != EXE_SB_OP);
        lane_o.sel     = 4'b1000 >> off_i;
        lane_o.wdata   = {4{reg2_i[7:0]}};
        lane_o.ldata   = (aluop_i == EXE_LB_OP) ? {{24{byte_dat[7]}}, byte_dat}
                                                : {24'h0, byte_dat};
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
        lane_o.is_mem   = 1'b1;
        lane_o.is_load  = (aluop_i != EXE_SH_OP);
        lane_o.misalign = off_i[0];
        lane_o.sel      = off_i[1] ? 4'b0011 : 4'b1100;
        lane_o.wdata    = {2{reg2_i[15:0]}};
        lane_o.ldata    = (aluop_i == EXE_LH_OP) ? {{16{half_dat[15]}}, half_dat}
                                                 : {16'h0, half_dat};
      end
      EXE_LW_OP, EXE_SW_OP: begin
        lane_o.is_mem   = 1'b1;
        lane_o.is_load  = (aluop_i == EXE_LW_OP);
        lane_o.misalign = |off_i;
        lane_o.sel      = 4'b1111;
        lane_o.wdata    = reg2_i;
        lane_o.ldata    = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: non-mem ops pass through with zero latency; a load/store takes
// IDLE->BUSY->DONE (3 cycles minimum), stalling the pipeline until the bus acknowledges.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        aluop_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              stallreq_o,
  output logic              misalign_o,
  mem_lsu_if.master         bus
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       bwdata_q, bwdata_d;
  logic [31:0]       rdata_q, rdata_d;
  lane_t             lane;
  logic              busy;

  // In DONE the held instruction is still on the inputs, so the lane decode
  // of aluop/offset applies equally to the latched read data.
  mem_lsu_lane u_lane (
    .aluop_i (aluop_i),
    .off_i   (mem_addr_i[1:0]),
    .reg2_i  (reg2_i),
    .rdata_i (rdata_q),
    .lane_o  (lane)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LSU_IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= 4'b0000;
      bwdata_q <= ZERO_WORD;
      rdata_q  <= ZERO_WORD;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      bwdata_q <= bwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    bwdata_d   = bwdata_q;
    rdata_d    = rdata_q;
    wd_o       = wd_i;
    wreg_o     = wreg_i;
    wdata_o    = wdata_i;
    stallreq_o = NO_STOP;
    misalign_o = 1'b0;

    case (state_q)
      LSU_IDLE: begin
        if (lane.is_mem) begin
          wreg_o = WRITE_DISABLE;
          if (lane.misalign) begin
            misalign_o = 1'b1;
          end else begin
            stallreq_o = STOP;
            state_d    = LSU_BUSY;
            we_d       = ~lane.is_load;
            addr_d     = {mem_addr_i[ADDR_W-1:2], 2'b00};
            sel_d      = lane.sel;
            bwdata_d   = lane.wdata;
          end
        end
      end
      LSU_BUSY: begin
        stallreq_o = STOP;
        wreg_o     = WRITE_DISABLE;
        if (bus.ack) begin
          rdata_d = bus.rdata;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
        if (lane.is_load) begin
          wdata_o = lane.ldata;
        end else begin
          wreg_o = WRITE_DISABLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase

    // The ex_mem register is also in reset, so the writeback side reads as a bubble.
    if (rst) begin
      wd_o       = 5'd0;
      wreg_o     = WRITE_DISABLE;
      wdata_o    = ZERO_WORD;
      stallreq_o = NO_STOP;
      misalign_o = 1'b0;
    end
  end

  assign busy      = (state_q == LSU_BUSY);
  assign bus.req   = busy;
  assign bus.we    = busy & we_q;
  assign bus.addr  = busy ? addr_q : '0;
  assign bus.sel   = busy ? sel_q : 4'b0000;
  assign bus.wdata = busy ? bwdata_q : ZERO_WORD;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus random loads/stores against a byte-addressed
// big-endian memory model; a word-wide bus slave applies stores through the DUT's lanes.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [31:0] mem_addr_i, reg2_i, wdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, misalign_o;

  always #5 clk = ~clk;

  mem_lsu_if #(.ADDR_W(32)) bus ();

  mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .mem_addr_i (mem_addr_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .wdata_i    (wdata_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .stallreq_o (stallreq_o),
    .misalign_o (misalign_o),
    .bus        (bus)
  );

  int n_asrt = 0;
  int n_fail = 0;

  logic [31:0] wmem [256];   // what the bus slave holds
  logic [7:0]  bmem [1024];  // reference byte memory

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_asrt++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic void classify(input logic [7:0] op, output int size, output bit ld,
                                   output bit sgn);
    size = 0; ld = 1'b0; sgn = 1'b0;
    case (op)
      8'hE0: begin size = 1; ld = 1; sgn = 1; end
      8'hE4: begin size = 1; ld = 1; end
      8'hE1: begin size = 2; ld = 1; sgn = 1; end
      8'hE5: begin size = 2; ld = 1; end
      8'hE3: begin size = 4; ld = 1; end
      8'hE8: size = 1;
      8'hE9: size = 2;
      8'hEB: size = 4;
      default: ;
    endcase
  endfunction

  task automatic set_word(input int a, input logic [31:0] w);
    wmem[a / 4] = w;
    for (int j = 0; j < 4; j++) bmem[a + j] = 8'(w >> (24 - 8 * j));
  endtask

  function automatic logic [31:0] ref_load(input int a, input int size, input bit sgn);
    logic [31:0] v;
    v = 32'h0;
    for (int j = 0; j < size; j++) v = (v << 8) | {24'h0, bmem[a + j]};
    if (sgn && size < 4 && v[8 * size - 1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return v;
  endfunction

  task automatic drive_nop();
    aluop_i = 8'h00; mem_addr_i = 32'h0; reg2_i = 32'h0;
    wd_i = 5'd0; wreg_i = 1'b0; wdata_i = 32'h0;
  endtask

  // Presents one instruction from the cycle after a posedge and plays ex_mem + bus slave
  // until the pipeline may advance. Returns #1 after the posedge ending the instruction.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input logic [4:0] wd, input logic wreg, input logic [31:0] wdat,
                        input int delay);
    int size, off, ai;
    bit ld, sgn, mis;
    logic [3:0] es;
    logic [31:0] ew;
    classify(op, size, ld, sgn);
    aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
    wd_i = wd; wreg_i = wreg; wdata_i = wdat;
    bus.ack = 1'($urandom_range(0, 1));
    bus.rdata = $urandom;
    off = int'(addr[1:0]);
    ai = int'(addr[9:0]);
    mis = (size != 0) && ((ai % size) != 0);
    @(negedge clk);
    chk("idle_req", {31'h0, bus.req}, 32'h0);
    chk("idle_misalign", {31'h0, misalign_o}, {31'h0, mis});
    if (size == 0) begin
      chk("pass_wd", {27'h0, wd_o}, {27'h0, wd});
      chk("pass_wreg", {31'h0, wreg_o}, {31'h0, wreg});
      chk("pass_wdata", wdata_o, wdat);
      chk("pass_stall", {31'h0, stallreq_o}, 32'h0);
      @(posedge clk); #1;
      return;
    end
    chk("idle_wreg", {31'h0, wreg_o}, 32'h0);
    chk("idle_stall", {31'h0, stallreq_o}, {31'h0, !mis});
    @(posedge clk); #1;
    if (mis) return;

    es = 4'b0000;
    for (int j = 0; j < size; j++) es[3 - off - j] = 1'b1;
    ew = (size == 1) ? {4{reg2[7:0]}} : (size == 2) ? {2{reg2[15:0]}} : reg2;
    for (int k = 0; k <= delay; k++) begin
      bus.ack = (k == delay);
      bus.rdata = (k == delay) ? wmem[ai / 4] : $urandom;
      @(negedge clk);
      chk("busy_req", {31'h0, bus.req}, 32'h1);
      chk("busy_we", {31'h0, bus.we}, {31'h0, !ld});
      chk("busy_addr", bus.addr, addr & 32'hFFFF_FFFC);
      chk("busy_sel", {28'h0, bus.sel}, {28'h0, es});
      if (!ld) chk("busy_wdata", bus.wdata, ew);
      chk("busy_stall", {31'h0, stallreq_o}, 32'h1);
      chk("busy_wreg", {31'h0, wreg_o}, 32'h0);
      if (k == delay && bus.we) begin
        for (int i = 0; i < 4; i++)
          if (bus.sel[3 - i]) begin
            wmem[ai / 4] = wmem[ai / 4] & ~(32'hFF << (24 - 8 * i));
            wmem[ai / 4] = wmem[ai / 4] | (bus.wdata & (32'hFF << (24 - 8 * i)));
          end
      end
      @(posedge clk); #1;
    end

    bus.ack = 1'($urandom_range(0, 1));
    bus.rdata = $urandom;
    @(negedge clk);
    chk("done_req", {31'h0, bus.req}, 32'h0);
    chk("done_stall", {31'h0, stallreq_o}, 32'h0);
    chk("done_wd", {27'h0, wd_o}, {27'h0, wd});
    chk("done_wreg", {31'h0, wreg_o}, {31'h0, ld && wreg});
    if (ld) chk("done_wdata", wdata_o, ref_load(ai, size, sgn));
    else for (int j = 0; j < size; j++) bmem[ai + j] = 8'(reg2 >> (8 * (size - 1 - j)));
    @(posedge clk); #1;
    bus.ack = 1'b0;
  endtask

  logic [7:0] ops [10];

  initial begin
    ops = '{8'hE0, 8'hE4, 8'hE1, 8'hE5, 8'hE3, 8'hE8, 8'hE9, 8'hEB, 8'h21, 8'h25};
    for (int a = 0; a < 1024; a += 4) set_word(a, $urandom);
    set_word(32'h100, 32'h11F2_3344);
    set_word(32'h300, 32'h8001_5A5A);
    set_word(32'h304, 32'hCAFE_BABE);

    rst = 1'b1;
    bus.ack = 1'b0;
    bus.rdata = 32'h0;
    drive_nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'h0, bus.req}, 32'h0);
    chk("rst_we", {31'h0, bus.we}, 32'h0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_sel", {28'h0, bus.sel}, 32'h0);
    chk("rst_bwdata", bus.wdata, 32'h0);
    chk("rst_stall", {31'h0, stallreq_o}, 32'h0);
    chk("rst_misalign", {31'h0, misalign_o}, 32'h0);
    chk("rst_wd", {27'h0, wd_o}, 32'h0);
    chk("rst_wreg", {31'h0, wreg_o}, 32'h0);
    chk("rst_wdata", wdata_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(8'h21, 32'h0, 32'h0, 5'd3, 1'b1, 32'h1234, 0);           // ADDU passthrough
    run_op(8'hE0, 32'h101, 32'h0, 5'd7, 1'b1, 32'h5555, 0);         // LB, immediate ack
    run_op(8'hE9, 32'h202, 32'hABCD, 5'd8, 1'b1, 32'h0, 5);         // SH, slow ack
    run_op(8'hE3, 32'h102, 32'h0, 5'd9, 1'b1, 32'h77, 0);           // LW misaligned
    run_op(8'h21, 32'h0, 32'h0, 5'd4, 1'b1, 32'h4444, 0);

    // reset arrives in BUSY together with an ack
    aluop_i = 8'hE3; mem_addr_i = 32'h304; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h99;
    @(negedge clk);
    chk("r5_issue_stall", {31'h0, stallreq_o}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; bus.ack = 1'b1; bus.rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("r5_req_until_edge", {31'h0, bus.req}, 32'h1);
    @(posedge clk); #1;
    bus.ack = 1'b0;
    @(negedge clk);
    chk("r5_req", {31'h0, bus.req}, 32'h0);
    chk("r5_sel", {28'h0, bus.sel}, 32'h0);
    chk("r5_stall", {31'h0, stallreq_o}, 32'h0);
    chk("r5_wreg", {31'h0, wreg_o}, 32'h0);
    chk("r5_wdata", wdata_o, 32'h0);
    chk("r5_wd", {27'h0, wd_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive_nop();
    @(negedge clk);
    chk("r5_after_req", {31'h0, bus.req}, 32'h0);
    chk("r5_after_stall", {31'h0, stallreq_o}, 32'h0);
    chk("r5_after_wreg", {31'h0, wreg_o}, 32'h0);
    @(posedge clk); #1;

    run_op(8'hE5, 32'h300, 32'h0, 5'd10, 1'b1, 32'h0, 1);           // LHU -> 0x00008001
    run_op(8'hE3, 32'h304, 32'h0, 5'd11, 1'b1, 32'h0, 0);           // LW  -> 0xCAFEBABE

    for (int n = 0; n < 300; n++) begin
      run_op(ops[$urandom_range(0, 9)], 32'h100 + $urandom_range(0, 63), $urandom,
             5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
